// File: rtl/vga_image_ctrl.sv
// VGA timing generator that scans a 1-bit image ROM, upscaled by 2^SCALE_SH,
// through a 3-stage pipeline: counters -> ROM address -> ROM data -> outputs.
module vga_image_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int SCALE_SH = 2,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              color_in,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_L  = HCW'(H_ACTIVE);
  localparam logic [VCW-1:0] V_ACT_L  = VCW'(V_ACTIVE);
  localparam logic [HCW-1:0] HS_BEG   = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VCW-1:0] VS_BEG   = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic              cnt_vld_q, cnt_vld_d;
  logic [HCW-1:0]    h_cnt_q, h_cnt_d;
  logic [VCW-1:0]    v_cnt_q, v_cnt_d;
  logic              frame_end;

  logic              vis_p1_q, vis_p1_d;
  logic              hs_p1_q, hs_p1_d;
  logic              vs_p1_q, vs_p1_d;
  logic              fs_p1_q, fs_p1_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  logic              vis_p2_q, vis_p2_d;
  logic              hs_p2_q, hs_p2_d;
  logic              vs_p2_q, vs_p2_d;
  logic              fs_p2_q, fs_p2_d;

  logic              color_q, color_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              active_q, active_d;
  logic              fstart_q, fstart_d;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [HCW-1:0] h,
                                                 input logic [VCW-1:0] v);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = ADDR_W'(v >> SCALE_SH);
    col = ADDR_W'(h >> SCALE_SH);
    return (row * ADDR_W'(IMG_W)) + col;
  endfunction

  assign frame_end = cnt_vld_q && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (frame_end && !enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counters go live one clock after entering RUN so every frame starts at (0,0).
    cnt_vld_d = (state_q == RUN) && (state_d == RUN);

    h_cnt_d = '0;
    v_cnt_d = '0;
    if (cnt_vld_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
    end
  end

  // Stage 0 -> 1: decode counters, form ROM address
  always_comb begin
    vis_p1_d = cnt_vld_q && (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
    hs_p1_d  = !(cnt_vld_q && (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    vs_p1_d  = !(cnt_vld_q && (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    fs_p1_d  = cnt_vld_q && (h_cnt_q == '0) && (v_cnt_q == '0);

    rom_addr_d = rom_addr_q;
    if (!cnt_vld_q) begin
      rom_addr_d = '0;
    end else if (vis_p1_d && (32'(h_cnt_q >> SCALE_SH) < IMG_W)
                          && (32'(v_cnt_q >> SCALE_SH) < IMG_H)) begin
      rom_addr_d = pix_addr(h_cnt_q, v_cnt_q);
    end
  end

  // Stage 1 -> 2: wait for the synchronous ROM; stage 2 -> 3: register outputs
  always_comb begin
    vis_p2_d = vis_p1_q;
    hs_p2_d  = hs_p1_q;
    vs_p2_d  = vs_p1_q;
    fs_p2_d  = fs_p1_q;

    color_d  = rom_data & vis_p2_q;
    active_d = vis_p2_q;
    hsync_d  = hs_p2_q;
    vsync_d  = vs_p2_q;
    fstart_d = fs_p2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_vld_q  <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      vis_p1_q   <= 1'b0;
      hs_p1_q    <= 1'b1;
      vs_p1_q    <= 1'b1;
      fs_p1_q    <= 1'b0;
      rom_addr_q <= '0;
      vis_p2_q   <= 1'b0;
      hs_p2_q    <= 1'b1;
      vs_p2_q    <= 1'b1;
      fs_p2_q    <= 1'b0;
      color_q    <= 1'b0;
      active_q   <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      fstart_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_vld_q  <= cnt_vld_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      vis_p1_q   <= vis_p1_d;
      hs_p1_q    <= hs_p1_d;
      vs_p1_q    <= vs_p1_d;
      fs_p1_q    <= fs_p1_d;
      rom_addr_q <= rom_addr_d;
      vis_p2_q   <= vis_p2_d;
      hs_p2_q    <= hs_p2_d;
      vs_p2_q    <= vs_p2_d;
      fs_p2_q    <= fs_p2_d;
      color_q    <= color_d;
      active_q   <= active_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      fstart_q   <= fstart_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign color_in    = color_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_image_ctrl.sv
// Bench for vga_image_ctrl with a scaled-down raster: 24-clock lines (16 visible,
// hsync on 18..21), 13-line frames (8 visible, vsync on lines 9..10), 4x2 image.
module tb_vga_image_ctrl;

  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_data = 1'b0;
  logic              color_in, hsync, vsync, active, frame_start;
  logic              rom_mode = 1'b0;

  int checks = 0;
  int errors = 0;
  int t = 0;

  vga_image_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .IMG_W(4), .IMG_H(2), .SCALE_SH(2), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rom_addr(rom_addr),
    .rom_data(rom_data), .color_in(color_in), .hsync(hsync), .vsync(vsync),
    .active(active), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: pattern is the address LSB, or all ones.
  always @(posedge clk) rom_data <= rom_mode ? 1'b1 : rom_addr[0];

  // t counts negedges since enable was driven; pixel i appears on the outputs at
  // t = i + 5 and its ROM address at t = i + 3.
  task automatic tick();
    @(negedge clk);
    t++;
  endtask

  task automatic goto_t(input int tt);
    while (t < tt) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; rom_mode = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
    checks++; if (color_in !== 1'b0) begin errors++; $display("FAIL reset_color: got %b expected 0", color_in); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fstart: got %b expected 0", frame_start); end
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rom_addr); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL idle_active: got %b expected 0", active); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL idle_fstart: got %b expected 0", frame_start); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL idle_hsync: got %b expected 1", hsync); end
  endtask

  task automatic test_frame_start();
    enable = 1'b1; t = 0;
    goto_t(4);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_early: got %b expected 0", frame_start); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL active_early: got %b expected 0", active); end
    goto_t(5);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fs_pulse: got %b expected 1", frame_start); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL active_first: got %b expected 1", active); end
    goto_t(6);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fs_width: got %b expected 0", frame_start); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL active_second: got %b expected 1", active); end
  endtask

  task automatic test_address();
    goto_t(7);   // pixel (4,0)
    checks++; if (rom_addr !== 5'd1) begin errors++; $display("FAIL addr_4_0: got %0d expected 1", rom_addr); end
    goto_t(9);
    checks++; if (color_in !== 1'b1) begin errors++; $display("FAIL color_4_0: got %b expected 1", color_in); end
    goto_t(174); // pixel (3,7)
    checks++; if (rom_addr !== 5'd4) begin errors++; $display("FAIL addr_3_7: got %0d expected 4", rom_addr); end
    goto_t(176);
    checks++; if (color_in !== 1'b0) begin errors++; $display("FAIL color_3_7: got %b expected 0", color_in); end
    goto_t(178); // pixel (5,7)
    checks++; if (color_in !== 1'b1) begin errors++; $display("FAIL color_5_7: got %b expected 1", color_in); end
    goto_t(186); // pixel (15,7), last visible
    checks++; if (rom_addr !== 5'd7) begin errors++; $display("FAIL addr_max: got %0d expected 7", rom_addr); end
    goto_t(188);
    checks++; if (color_in !== 1'b1) begin errors++; $display("FAIL color_max: got %b expected 1", color_in); end
    goto_t(191); // pixel (20,7), blanking holds address
    checks++; if (rom_addr !== 5'd7) begin errors++; $display("FAIL addr_hold: got %0d expected 7", rom_addr); end
    goto_t(193);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL active_blank: got %b expected 0", active); end
    checks++; if (color_in !== 1'b0) begin errors++; $display("FAIL color_blank: got %b expected 0", color_in); end
  endtask

  task automatic test_sync_timing();
    int h_fall[2];
    int v_fall[2];
    int nh = 0, nv = 0, hs_len = 0, vs_len = 0, hs_w = 0, vs_w = 0;
    logic prev_hs, prev_vs;
    h_fall[0] = 0; h_fall[1] = 0; v_fall[0] = 0; v_fall[1] = 0;
    prev_hs = hsync; prev_vs = vsync;
    while (t < 560) begin
      tick();
      if (prev_hs && !hsync) begin
        if (nh < 2) h_fall[nh] = t;
        nh++; hs_len = 0;
      end
      if (!hsync) hs_len++;
      else if (!prev_hs && nh > 0) hs_w = hs_len;
      if (prev_vs && !vsync) begin
        if (nv < 2) v_fall[nv] = t;
        nv++; vs_len = 0;
      end
      if (!vsync) vs_len++;
      else if (!prev_vs && nv > 0) vs_w = vs_len;
      prev_hs = hsync; prev_vs = vsync;
    end
    checks++; if (h_fall[0] != 215) begin errors++; $display("FAIL hsync_first: got t=%0d expected 215", h_fall[0]); end
    checks++; if (h_fall[1] - h_fall[0] != 24) begin errors++; $display("FAIL hsync_period: got %0d expected 24", h_fall[1] - h_fall[0]); end
    checks++; if (hs_w != 4) begin errors++; $display("FAIL hsync_width: got %0d expected 4", hs_w); end
    checks++; if (v_fall[0] != 221) begin errors++; $display("FAIL vsync_first: got t=%0d expected 221", v_fall[0]); end
    checks++; if (v_fall[1] - v_fall[0] != 312) begin errors++; $display("FAIL vsync_period: got %0d expected 312", v_fall[1] - v_fall[0]); end
    checks++; if (vs_w != 48) begin errors++; $display("FAIL vsync_width: got %0d expected 48", vs_w); end
  endtask

  task automatic test_all_ones();
    int lc[13];
    int total = 0, blank_ones = 0, run = 0, max_run = 0, full = 0, line;
    for (int i = 0; i < 13; i++) lc[i] = 0;
    rom_mode = 1'b1;
    goto_t(628);
    while (t < 940) begin
      tick();
      line = (t - 629) / 24;
      if (color_in === 1'b1) begin
        total++; lc[line]++; run++;
        if (line >= 8) blank_ones++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    for (int i = 0; i < 8; i++) if (lc[i] == 16) full++;
    checks++; if (total != 128) begin errors++; $display("FAIL ones_total: got %0d expected 128", total); end
    checks++; if (blank_ones != 0) begin errors++; $display("FAIL ones_vblank: got %0d expected 0", blank_ones); end
    checks++; if (max_run != 16) begin errors++; $display("FAIL ones_run: got %0d expected 16", max_run); end
    checks++; if (full != 8) begin errors++; $display("FAIL ones_lines: got %0d expected 8", full); end
  endtask

  task automatic test_drop_enable();
    int act_cnt, vs_low, fs_cnt = 0, act_after = 0, hs_after = 0;
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL drop_fs_start: got %b expected 1", frame_start); end
    act_cnt = int'(active); vs_low = int'(!vsync);
    while (t < 1252) begin
      if (t == 1037) enable = 1'b0;  // mid-frame, line 4
      tick();
      act_cnt += int'(active); vs_low += int'(!vsync);
    end
    checks++; if (act_cnt != 128) begin errors++; $display("FAIL drop_active: got %0d expected 128", act_cnt); end
    checks++; if (vs_low != 48) begin errors++; $display("FAIL drop_vsync: got %0d expected 48", vs_low); end
    tick();
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL drop_idle_sync: got %b%b expected 11", hsync, vsync); end
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL drop_idle_addr: got %0d expected 0", rom_addr); end
    repeat (400) begin
      tick();
      fs_cnt += int'(frame_start); act_after += int'(active); hs_after += int'(!hsync);
    end
    checks++; if (fs_cnt != 0) begin errors++; $display("FAIL drop_no_fs: got %0d expected 0", fs_cnt); end
    checks++; if (act_after != 0 || hs_after != 0) begin errors++; $display("FAIL drop_no_raster: got %0d/%0d expected 0/0", act_after, hs_after); end
  endtask

  task automatic test_reset_midframe();
    enable = 1'b1; t = 0;
    goto_t(110);  // counters at (12,4)
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_active_pre: got %b expected 1", active); end
    checks++; if (rom_addr !== 5'd6) begin errors++; $display("FAIL mid_addr_pre: got %0d expected 6", rom_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL mid_active_rst: got %b expected 0", active); end
    checks++; if (color_in !== 1'b0) begin errors++; $display("FAIL mid_color_rst: got %b expected 0", color_in); end
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL mid_addr_rst: got %0d expected 0", rom_addr); end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin errors++; $display("FAIL mid_sync_rst: got %b%b expected 11", hsync, vsync); end
    @(negedge clk);
    rst_n = 1'b1; t = 0;
    goto_t(4);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL mid_fs_early: got %b expected 0", frame_start); end
    goto_t(5);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_fs_restart: got %b expected 1", frame_start); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL mid_active_restart: got %b expected 1", active); end
  endtask

  task automatic test_toggle_enable();
    int fs_cnt = 0, act_cnt = 0;
    while (t < 316) begin
      if (t == 50) enable = 1'b0;
      if (t == 60) enable = 1'b1;
      tick();
      fs_cnt += int'(frame_start); act_cnt += int'(active);
    end
    checks++; if (fs_cnt != 0) begin errors++; $display("FAIL toggle_fs_extra: got %0d expected 0", fs_cnt); end
    checks++; if (act_cnt != 127) begin errors++; $display("FAIL toggle_active: got %0d expected 127", act_cnt); end
    tick();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL toggle_next_fs: got %b expected 1", frame_start); end
    tick();
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL toggle_fs_width: got %b expected 0", frame_start); end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_address();
    test_sync_timing();
    test_all_ones();
    test_drop_enable();
    test_reset_midframe();
    test_toggle_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_image_ctrl.md
VGA_IMAGE_CTRL -- requirements
Module: vga_image_ctrl

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48 (line = 800 clocks); V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (frame = 525 lines).
REQ-002 SHALL have parameters: IMG_W 160, IMG_H 120 (stored image size in pixels), SCALE_SH 2 (each image pixel upscaled 2^SCALE_SH in x and y), ADDR_W 15 (ROM address width).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; clock port clk, reset port rst_n.
REQ-004 clk  input  1  pixel clock (25 MHz nominal); all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  request to display; sampled only at frame boundaries.
REQ-007 rom_addr  output  ADDR_W  address to 1-bit image ROM, registered.
REQ-008 rom_data  input  1  ROM pixel; synchronous ROM, valid one clock after rom_addr.
REQ-009 color_in  output  1  monochrome pixel to the RGB expander, registered.
REQ-010 hsync, vsync  output  1 each  active-low sync pulses, registered.
REQ-011 active  output  1  high while color_in belongs to the visible area.
REQ-012 frame_start  output  1  one-clock pulse with the first visible pixel of each frame.

Function
REQ-013 SHALL implement states IDLE and RUN in a registered FSM.
REQ-014 IDLE: h_cnt = 0, v_cnt = 0; hsync = vsync = 1; active = color_in = frame_start = 0; rom_addr = 0.
REQ-015 IDLE -> RUN on the first clock with enable = 1; counting starts at (h_cnt, v_cnt) = (0, 0) on the next clock.
REQ-016 RUN: h_cnt increments 0..799 and wraps to 0; v_cnt increments when h_cnt wraps, 0..524, and wraps to 0.
REQ-017 RUN -> IDLE only when h_cnt = 799, v_cnt = 524 and enable = 0; mid-frame deassertion of enable is ignored until the frame completes.
REQ-018 Visible area: h_cnt < 640 and v_cnt < 480; hsync low for h_cnt in [656, 751]; vsync low for v_cnt in [490, 491].
REQ-019 rom_addr, registered one clock after the counters, SHALL be (v_cnt >> SCALE_SH) * IMG_W + (h_cnt >> SCALE_SH) when visible, else held at its previous value.
REQ-020 Address arithmetic SHALL be unsigned, computed in ADDR_W bits with no overflow; the maximum address is 19199.
REQ-021 color_in SHALL be rom_data registered, ANDed with the delayed visible flag; 0 outside the visible area.
REQ-022 hsync, vsync and active SHALL be delayed so that all outputs align with color_in; total latency from counter value to outputs is 3 clocks.
REQ-023 frame_start SHALL pulse for exactly one clock, aligned with active for pixel (0, 0) of each frame.
REQ-024 After RUN -> IDLE, the 3-clock pipeline SHALL flush: the remaining pipelined blanking values are output before the outputs take their IDLE values.
REQ-025 Re-entry to RUN from IDLE SHALL always begin a fresh frame at (0, 0); no partial frames.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, zero the counters and pipeline, hsync = vsync = 1, and all other outputs 0, regardless of clk.
REQ-027 Reset asserted mid-frame SHALL abort the frame; after release the block waits in IDLE for enable.
REQ-028 Reset release SHALL be synchronous to clk; the first state change occurs on the first rising edge after rst_n goes high.

Verification
REQ-029 Reset then enable = 1: frame_start rises 4 clocks after enable is sampled; hsync period is 800 clocks, low width 96; vsync period is 420000 clocks, low width 1600.
REQ-030 Address check with ROM model = address LSB: at visible (h, v) = (4, 0), rom_addr = 1; at (639, 479), rom_addr = 19199; at (3, 7), rom_addr = 160.
REQ-031 ROM model all-ones: color_in = 1 for exactly 640 consecutive clocks per visible line; 0 during the 160 blanking clocks and during all 45 blanking lines.
REQ-032 Drop enable at v_cnt = 200: the frame completes through v_cnt = 524, the block then enters IDLE, hsync = vsync = 1, and there is no further frame_start.
REQ-033 Assert rst_n low at (h, v) = (300, 100): outputs reach their IDLE values within the same cycle (asynchronous); with enable still 1 after release, a new frame starts at (0, 0).
REQ-034 Toggle enable 1 -> 0 -> 1 within one frame: there is no interruption, and the following frame starts immediately after wrap with frame_start pulsing once per frame.
